cdb_arbiter: RTL and testbench

//  Shares the single common data bus (CDB) between the result producers: ALU results from the

---
 rtl/cdb_arbiter.sv | 228 ++++++++++++++++++++++
 tb/tb_cdb_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// ---------------------------------------------------------------------------
// cdb_arbiter
//   Shares the single common data bus (CDB) between result producers
//   (0 = RS/ALU, 1 = LSB, 2 = spare). Each source owns a small FIFO so that
//   producers never need to be back-pressured mid-operation. A round-robin
//   scheduler drains at most one entry per cycle onto a registered CDB
//   broadcast consumed by the ROB, RS and LSB.
//
// Optional feature macro: CDB_BYPASS_EN
//   When defined, a result pushed while every FIFO is empty is sent to the
//   CDB at the same edge (1-cycle latency) instead of being enqueued.
//   When undefined, every result passes through its FIFO (2-cycle latency).
//
// Ports
//   clk_in      in   clock, rising edge
//   rst_in      in   asynchronous active-low reset
//   rdy_in      in   global ready; low freezes all state and ignores pushes
//   clear       in   synchronous flush (mispredict); err_ovf is kept
//   src_valid   in   [N_SRC]        per-source push strobe
//   src_rob_id  in   [N_SRC*ROB_W]  per-source ROB tag, source i at [i*ROB_W +: ROB_W]
//   src_val     in   [N_SRC*32]     per-source result, packed likewise
//   src_full    out  [N_SRC]        registered almost-full; source must stop pushing
//   cdb_req     out  registered CDB valid
//   cdb_rob_id  out  [ROB_W]        registered CDB tag
//   cdb_val     out  [32]           registered CDB value
//   cdb_src     out  [SRC_W]        registered id of the granted source
//   err_ovf     out  sticky flag: a push was dropped on a full FIFO
// ---------------------------------------------------------------------------
`ifndef ROB_INDEX_BIT
`define ROB_INDEX_BIT 4
`endif

module cdb_arbiter #(
  parameter int N_SRC   = 3,
  parameter int Q_DEPTH = 4,
  parameter int ROB_W   = `ROB_INDEX_BIT,
  localparam int SRC_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic                   clear,
  input  logic [N_SRC-1:0]       src_valid,
  input  logic [N_SRC*ROB_W-1:0] src_rob_id,
  input  logic [N_SRC*32-1:0]    src_val,
  output logic [N_SRC-1:0]       src_full,
  output logic                   cdb_req,
  output logic [ROB_W-1:0]       cdb_rob_id,
  output logic [31:0]            cdb_val,
  output logic [SRC_W-1:0]       cdb_src,
  output logic                   err_ovf
);

  localparam int PTR_W = $clog2(Q_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Per-source FIFO bookkeeping
  logic [PTR_W-1:0] head_reg   [N_SRC];
  logic [PTR_W-1:0] tail_reg   [N_SRC];
  logic [CNT_W-1:0] count_reg  [N_SRC];
  logic [CNT_W-1:0] count_next [N_SRC];
  logic [ROB_W-1:0] head_rob   [N_SRC];
  logic [31:0]      head_val   [N_SRC];

  logic [SRC_W-1:0] rr_ptr_reg;
  logic [SRC_W-1:0] rr_next;

  logic [N_SRC-1:0] non_empty;
  logic [N_SRC-1:0] pop_vec;
  logic [N_SRC-1:0] push_ok_vec;
  logic [N_SRC-1:0] drop_vec;
  logic [N_SRC-1:0] byp_take_vec;

  logic             grant_valid;
  logic [SRC_W-1:0] grant_idx;

  logic             sel_valid;
  logic [SRC_W-1:0] sel_idx;
  logic [ROB_W-1:0] sel_rob;
  logic [31:0]      sel_val;

  logic             advance;
  assign advance = rdy_in & ~clear;

  // Round-robin scan over pre-edge occupancy, starting at rr_ptr.
  always_comb begin
    logic [SRC_W:0]   sum;
    logic [SRC_W-1:0] idx;
    grant_valid = 1'b0;
    grant_idx   = '0;
    sum         = '0;
    idx         = '0;
    for (int k = 0; k < N_SRC; k++) begin
      sum = {1'b0, rr_ptr_reg} + (SRC_W+1)'(k);
      if (sum >= (SRC_W+1)'(N_SRC)) sum = sum - (SRC_W+1)'(N_SRC);
      idx = sum[SRC_W-1:0];
      if (!grant_valid && non_empty[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = idx;
      end
    end
  end

`ifdef CDB_BYPASS_EN
  // With every FIFO empty, the round-robin winner among the live pushes
  // skips its FIFO and goes straight to the CDB register.
  logic             byp_valid;
  logic [SRC_W-1:0] byp_idx;

  always_comb begin
    logic [SRC_W:0]   sum;
    logic [SRC_W-1:0] idx;
    byp_valid = 1'b0;
    byp_idx   = '0;
    sum       = '0;
    idx       = '0;
    if (~|non_empty) begin
      for (int k = 0; k < N_SRC; k++) begin
        sum = {1'b0, rr_ptr_reg} + (SRC_W+1)'(k);
        if (sum >= (SRC_W+1)'(N_SRC)) sum = sum - (SRC_W+1)'(N_SRC);
        idx = sum[SRC_W-1:0];
        if (!byp_valid && src_valid[idx]) begin
          byp_valid = 1'b1;
          byp_idx   = idx;
        end
      end
    end
  end
`endif

  // CDB source selection: FIFO head of the granted source, or the bypassed push.
  always_comb begin
    sel_valid = grant_valid;
    sel_idx   = grant_idx;
    sel_rob   = head_rob[grant_idx];
    sel_val   = head_val[grant_idx];
`ifdef CDB_BYPASS_EN
    if (byp_valid) begin
      sel_valid = 1'b1;
      sel_idx   = byp_idx;
      sel_rob   = src_rob_id[byp_idx*ROB_W +: ROB_W];
      sel_val   = src_val[byp_idx*32 +: 32];
    end
`endif
    rr_next = (sel_idx == SRC_W'(N_SRC-1)) ? '0 : sel_idx + 1'b1;
  end

  generate
    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
      logic [ROB_W-1:0] rob_mem [Q_DEPTH];
      logic [31:0]      val_mem [Q_DEPTH];
      logic             push_req;

      assign non_empty[gi] = (count_reg[gi] != '0);
      assign pop_vec[gi]   = grant_valid && (grant_idx == SRC_W'(gi));
`ifdef CDB_BYPASS_EN
      assign byp_take_vec[gi] = byp_valid && (byp_idx == SRC_W'(gi));
`else
      assign byp_take_vec[gi] = 1'b0;
`endif
      assign push_req = src_valid[gi] & ~byp_take_vec[gi];
      // A full FIFO still accepts a push when its head leaves in the same cycle.
      assign push_ok_vec[gi] = push_req &&
                               ((count_reg[gi] != CNT_W'(Q_DEPTH)) || pop_vec[gi]);
      assign drop_vec[gi]    = push_req && !push_ok_vec[gi];
      assign count_next[gi]  = count_reg[gi] + CNT_W'(push_ok_vec[gi])
                                             - CNT_W'(pop_vec[gi]);

      // Storage carries no reset; validity is tracked by the counters.
      always_ff @(posedge clk_in) begin
        if (advance && push_ok_vec[gi]) begin
          rob_mem[tail_reg[gi]] <= src_rob_id[gi*ROB_W +: ROB_W];
          val_mem[tail_reg[gi]] <= src_val[gi*32 +: 32];
        end
      end

      assign head_rob[gi] = rob_mem[head_reg[gi]];
      assign head_val[gi] = val_mem[head_reg[gi]];
    end
  endgenerate

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < N_SRC; i++) begin
        head_reg[i]  <= '0;
        tail_reg[i]  <= '0;
        count_reg[i] <= '0;
      end
      src_full   <= '0;
      rr_ptr_reg <= '0;
      cdb_req    <= 1'b0;
      cdb_rob_id <= '0;
      cdb_val    <= '0;
      cdb_src    <= '0;
      err_ovf    <= 1'b0;
    end else if (rdy_in) begin
      if (clear) begin
        for (int i = 0; i < N_SRC; i++) begin
          head_reg[i]  <= '0;
          tail_reg[i]  <= '0;
          count_reg[i] <= '0;
        end
        src_full   <= '0;
        rr_ptr_reg <= '0;
        cdb_req    <= 1'b0;
      end else begin
        for (int i = 0; i < N_SRC; i++) begin
          if (push_ok_vec[i]) tail_reg[i] <= tail_reg[i] + PTR_W'(1);
          if (pop_vec[i])     head_reg[i] <= head_reg[i] + PTR_W'(1);
          count_reg[i] <= count_next[i];
          // Asserted one slot early to absorb the push already in flight.
          src_full[i]  <= (count_next[i] >= CNT_W'(Q_DEPTH-1));
        end
        if (|drop_vec) err_ovf <= 1'b1;
        if (sel_valid) begin
          cdb_req    <= 1'b1;
          cdb_rob_id <= sel_rob;
          cdb_val    <= sel_val;
          cdb_src    <= sel_idx;
          rr_ptr_reg <= rr_next;
        end else begin
          cdb_req <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cdb_arbiter
//   Self-checking bench for cdb_arbiter (N_SRC=3, Q_DEPTH=4, ROB_W=4).
//   A queue-based reference model tracks every pending result tagged with
//   its source; grants, drops and almost-full flags are derived from it.
// ---------------------------------------------------------------------------
module tb_cdb_arbiter;

  localparam int NS = 3;
  localparam int QD = 4;
  localparam int RW = 4;
`ifdef CDB_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b1;
  logic          rdy_in = 1'b1;
  logic          clear = 1'b0;
  logic [2:0]    src_valid = '0;
  logic [11:0]   src_rob_id = '0;
  logic [95:0]   src_val = '0;
  logic [2:0]    src_full;
  logic          cdb_req;
  logic [3:0]    cdb_rob_id;
  logic [31:0]   cdb_val;
  logic [1:0]    cdb_src;
  logic          err_ovf;

  cdb_arbiter #(.N_SRC(NS), .Q_DEPTH(QD), .ROB_W(RW)) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .rdy_in     (rdy_in),
    .clear      (clear),
    .src_valid  (src_valid),
    .src_rob_id (src_rob_id),
    .src_val    (src_val),
    .src_full   (src_full),
    .cdb_req    (cdb_req),
    .cdb_rob_id (cdb_rob_id),
    .cdb_val    (cdb_val),
    .cdb_src    (cdb_src),
    .err_ovf    (err_ovf)
  );

  always #5 clk_in = ~clk_in;

  // ---------------- reference model ----------------
  typedef struct {
    int          s;
    logic [3:0]  rob;
    logic [31:0] val;
  } ent_t;

  ent_t        mq[$];
  int          m_rr;
  logic        m_req;
  logic [3:0]  m_rob;
  logic [31:0] m_val;
  logic [1:0]  m_src;
  logic [2:0]  m_full;
  logic        m_err;

  int n_checks = 0;
  int n_errs   = 0;

  function automatic int mcount(int s);
    int c = 0;
    foreach (mq[j]) if (mq[j].s == s) c++;
    return c;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_rr = 0; m_req = 0; m_rob = 0; m_val = 0; m_src = 0; m_full = 0; m_err = 0;
  endtask

  task automatic model_step(input logic rdy, input logic clr, input logic [2:0] v,
                            input logic [11:0] rob, input logic [95:0] val);
    int   cnt[3];
    int   g, w, idx;
    bit   from_in;
    ent_t e;
    if (!rdy) return;
    if (clr) begin
      mq.delete();
      m_req = 0; m_rr = 0; m_full = 0;
      return;
    end
    for (int i = 0; i < NS; i++) cnt[i] = mcount(i);
    g = -1;
    for (int k = 0; k < NS; k++) begin
      idx = (m_rr + k) % NS;
      if (g < 0 && cnt[idx] > 0) g = idx;
    end
    w = g;
    from_in = 0;
`ifdef CDB_BYPASS_EN
    if (cnt[0] == 0 && cnt[1] == 0 && cnt[2] == 0) begin
      for (int k = 0; k < NS; k++) begin
        idx = (m_rr + k) % NS;
        if (w < 0 && v[idx]) begin w = idx; from_in = 1; end
      end
    end
`endif
    if (w >= 0) begin
      m_req = 1;
      m_src = 2'(w);
      m_rr  = (w + 1) % NS;
      if (from_in) begin
        m_rob = rob[w*4 +: 4];
        m_val = val[w*32 +: 32];
      end else begin
        for (int j = 0; j < mq.size(); j++) begin
          if (mq[j].s == g) begin
            m_rob = mq[j].rob;
            m_val = mq[j].val;
            mq.delete(j);
            break;
          end
        end
      end
    end else begin
      m_req = 0;
    end
    for (int i = 0; i < NS; i++) begin
      if (v[i] && !(from_in && w == i)) begin
        if (cnt[i] < QD || g == i) begin
          e.s = i; e.rob = rob[i*4 +: 4]; e.val = val[i*32 +: 32];
          mq.push_back(e);
        end else begin
          m_err = 1;
        end
      end
    end
    for (int i = 0; i < NS; i++) m_full[i] = (mcount(i) >= QD - 1);
  endtask

  // Apply one cycle of stimulus, advance the model, sample 1 time unit after the edge.
  task automatic drive(input logic rdy, input logic clr, input logic [2:0] v,
                       input logic [11:0] rob, input logic [95:0] val);
    rdy_in = rdy; clear = clr; src_valid = v; src_rob_id = rob; src_val = val;
    model_step(rdy, clr, v, rob, val);
    @(posedge clk_in);
    #1;
    rdy_in = 1'b1; clear = 1'b0; src_valid = '0;
  endtask

  task automatic drive_rand(input logic rdy, input logic clr, input logic [2:0] v);
    logic [11:0] rob;
    logic [95:0] val;
    rob = 12'($urandom);
    val = {$urandom, $urandom, $urandom};
    drive(rdy, clr, v, rob, val);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2 rst_in = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
    model_reset();
    n_checks++;
    if ({cdb_req, cdb_rob_id, cdb_val, cdb_src} !== 39'd0) begin
      n_errs++;
      $display("FAIL reset_cdb: got req=%0b tag=%0d val=%h src=%0d, want all zero",
               cdb_req, cdb_rob_id, cdb_val, cdb_src);
    end
    n_checks++;
    if ({src_full, err_ovf} !== 4'd0) begin
      n_errs++;
      $display("FAIL reset_flags: got full=%b err=%0b, want 000/0", src_full, err_ovf);
    end
    @(negedge clk_in);
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_single_push();
    for (int c = 0; c < 4; c++) begin
      if (c == 0) drive(1'b1, 1'b0, 3'b001, 12'h005, 96'h1234);
      else        drive_rand(1'b1, 1'b0, 3'b000);
      n_checks++;
      if ({cdb_req, cdb_rob_id, cdb_val, cdb_src} !== {m_req, m_rob, m_val, m_src}) begin
        n_errs++;
        $display("FAIL single_cdb c%0d: got req=%0b tag=%0d val=%h src=%0d, want req=%0b tag=%0d val=%h src=%0d",
                 c, cdb_req, cdb_rob_id, cdb_val, cdb_src, m_req, m_rob, m_val, m_src);
      end
      // Spec-level latency independent of the model.
      n_checks++;
      if (cdb_req !== (c == LAT - 1)) begin
        n_errs++;
        $display("FAIL single_latency c%0d: got req=%0b want %0b", c, cdb_req, (c == LAT - 1));
      end
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] v;
    drive_rand(1'b1, 1'b1, 3'b000);
    for (int c = 0; c < 30; c++) begin
      v = ~m_full;
      drive_rand(1'b1, 1'b0, v);
      if (cdb_req) $display("rr beat c%0d: src=%0d tag=%0d val=%h", c, cdb_src, cdb_rob_id, cdb_val);
      n_checks++;
      if ({cdb_req, cdb_rob_id, cdb_val, cdb_src} !== {m_req, m_rob, m_val, m_src}) begin
        n_errs++;
        $display("FAIL rr_cdb c%0d: got req=%0b tag=%0d val=%h src=%0d, want req=%0b tag=%0d val=%h src=%0d",
                 c, cdb_req, cdb_rob_id, cdb_val, cdb_src, m_req, m_rob, m_val, m_src);
      end
      n_checks++;
      if (src_full !== m_full) begin
        n_errs++;
        $display("FAIL rr_full c%0d: got %b want %b", c, src_full, m_full);
      end
      // All sources stay busy, so grants must rotate strictly 0,1,2,...
      if (c >= LAT - 1) begin
        n_checks++;
        if (cdb_req !== 1'b1 || cdb_src !== 2'((c - (LAT - 1)) % NS)) begin
          n_errs++;
          $display("FAIL rr_rotation c%0d: got req=%0b src=%0d want req=1 src=%0d",
                   c, cdb_req, cdb_src, (c - (LAT - 1)) % NS);
        end
      end
    end
  endtask

  task automatic test_overflow();
    drive_rand(1'b1, 1'b1, 3'b000);
    for (int c = 0; c < 8; c++) begin
      drive_rand(1'b1, 1'b0, 3'b111);
      n_checks++;
      if ({err_ovf, src_full} !== {m_err, m_full}) begin
        n_errs++;
        $display("FAIL ovf_flags c%0d: got err=%0b full=%b want err=%0b full=%b",
                 c, err_ovf, src_full, m_err, m_full);
      end
      n_checks++;
      if ({cdb_req, cdb_rob_id, cdb_val, cdb_src} !== {m_req, m_rob, m_val, m_src}) begin
        n_errs++;
        $display("FAIL ovf_cdb c%0d: got req=%0b tag=%0d val=%h src=%0d, want req=%0b tag=%0d val=%h src=%0d",
                 c, cdb_req, cdb_rob_id, cdb_val, cdb_src, m_req, m_rob, m_val, m_src);
      end
    end
    drive_rand(1'b1, 1'b1, 3'b000);
    n_checks++;
    if (err_ovf !== 1'b1) begin
      n_errs++;
      $display("FAIL ovf_sticky: got err=%0b want 1 after clear", err_ovf);
    end
  endtask

  task automatic test_clear();
    drive_rand(1'b1, 1'b0, 3'b111);
    drive_rand(1'b1, 1'b0, 3'b111);
    drive_rand(1'b1, 1'b1, 3'b111);
    n_checks++;
    if ({cdb_req, src_full} !== 4'd0) begin
      n_errs++;
      $display("FAIL clear_now: got req=%0b full=%b want 0/000", cdb_req, src_full);
    end
    for (int c = 0; c < 3; c++) begin
      drive_rand(1'b1, 1'b0, 3'b000);
      n_checks++;
      if ({cdb_req, cdb_rob_id, cdb_val, cdb_src, src_full} !== {m_req, m_rob, m_val, m_src, m_full}) begin
        n_errs++;
        $display("FAIL clear_after c%0d: got req=%0b tag=%0d full=%b want req=%0b tag=%0d full=%b",
                 c, cdb_req, cdb_rob_id, src_full, m_req, m_rob, m_full);
      end
    end
  endtask

  task automatic test_stall();
    drive_rand(1'b1, 1'b0, 3'b111);
    drive_rand(1'b1, 1'b0, 3'b111);
    for (int c = 0; c < 10; c++) begin
      if (c < 3) drive_rand(1'b0, 1'b0, 3'b111);
      else       drive_rand(1'b1, 1'b0, 3'b000);
      n_checks++;
      if ({cdb_req, cdb_rob_id, cdb_val, cdb_src, src_full} !== {m_req, m_rob, m_val, m_src, m_full}) begin
        n_errs++;
        $display("FAIL stall c%0d: got req=%0b tag=%0d val=%h src=%0d full=%b, want req=%0b tag=%0d val=%h src=%0d full=%b",
                 c, cdb_req, cdb_rob_id, cdb_val, cdb_src, src_full, m_req, m_rob, m_val, m_src, m_full);
      end
    end
  endtask

  task automatic test_async_reset();
    drive_rand(1'b1, 1'b0, 3'b111);
    drive_rand(1'b1, 1'b0, 3'b111);
    #2 rst_in = 1'b0;
    #1;
    n_checks++;
    if ({cdb_req, src_full, err_ovf} !== 5'd0) begin
      n_errs++;
      $display("FAIL async_reset: got req=%0b full=%b err=%0b want 0/000/0", cdb_req, src_full, err_ovf);
    end
    model_reset();
    @(negedge clk_in);
    rst_in = 1'b1;
    for (int c = 0; c < 2; c++) begin
      drive_rand(1'b1, 1'b0, 3'b000);
      n_checks++;
      if (cdb_req !== 1'b0) begin
        n_errs++;
        $display("FAIL async_reset_empty c%0d: got req=%0b want 0", c, cdb_req);
      end
    end
  endtask

  task automatic test_random();
    logic       rdy, clr;
    logic [2:0] v;
    for (int c = 0; c < 400; c++) begin
      rdy = ($urandom_range(0, 9) != 0);
      clr = ($urandom_range(0, 39) == 0);
      v   = 3'($urandom);
      if ($urandom_range(0, 1) == 0) v = v & ~m_full;
      drive_rand(rdy, clr, v);
      n_checks++;
      if ({cdb_req, cdb_rob_id, cdb_val, cdb_src, src_full, err_ovf} !==
          {m_req, m_rob, m_val, m_src, m_full, m_err}) begin
        n_errs++;
        $display("FAIL random c%0d: got req=%0b tag=%0d val=%h src=%0d full=%b err=%0b, want req=%0b tag=%0d val=%h src=%0d full=%b err=%0b",
                 c, cdb_req, cdb_rob_id, cdb_val, cdb_src, src_full, err_ovf,
                 m_req, m_rob, m_val, m_src, m_full, m_err);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_push();
    test_round_robin();
    test_overflow();
    test_clear();
    test_stall();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
